// File: rtl/control.sv
// CSR sparse-matrix x dense-vector engine: walks row pointers,
// gathers x by column index and emits one dot product per row.
module control #(
  parameter int ROWS = 32,
  parameter int DW   = 32
) (
  input  logic          Clk,
  input  logic [DW-1:0] v_values_base,
  input  logic [DW-1:0] wdata_col_base,
  input  logic [DW-1:0] matrix_base,
  output logic [DW-1:0] addr1,
  output logic [DW-1:0] addr2,
  input  logic [DW-1:0] dataIn1,
  input  logic [DW-1:0] dataIn2,
  input  logic          Rst,
  input  logic [DW-1:0] row_base,
  input  logic          RD,
  input  logic [DW-1:0] csize,
  output logic [DW-1:0] y_out,
  output logic          y_valid,
  output logic [DW-1:0] y_row,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROWEND,
    S_FETCH,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] k_q, k_d;
  logic [DW-1:0] end_q, end_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] col_q, col_d;
  logic [DW-1:0] mval_q, mval_d;
  logic [DW-1:0] y_out_q, y_out_d;
  logic [DW-1:0] y_row_q, y_row_d;
  logic          y_valid_q, y_valid_d;
  logic          done_q, done_d;
  logic          last_row;

  assign last_row = (r_q == DW'(ROWS - 1));

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    end_d     = end_q;
    acc_d     = acc_q;
    col_d     = col_q;
    mval_d    = mval_q;
    y_out_d   = y_out_q;
    y_row_d   = y_row_q;
    y_valid_d = 1'b0;
    done_d    = done_q;
    addr1     = '0;
    addr2     = '0;
    // RD low outside IDLE/DONE freezes every register update
    unique case (state_q)
      S_IDLE: begin
        if (RD) state_d = S_INIT;
      end
      S_INIT: begin
        addr1 = row_base;
        if (RD) begin
          k_d     = dataIn1;
          state_d = S_ROWEND;
        end
      end
      S_ROWEND: begin
        addr1 = row_base + r_q + DW'(1);
        if (RD) begin
          end_d   = (dataIn1 < csize) ? dataIn1 : csize;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (k_q >= end_q) begin
          if (RD) state_d = S_EMIT;
        end else begin
          addr1 = wdata_col_base + DW'(ROWS + 1) + k_q;
          addr2 = matrix_base + k_q;
          if (RD) begin
            col_d   = dataIn1;
            mval_d  = dataIn2;
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        addr2 = v_values_base + col_q;
        if (RD) begin
          acc_d   = acc_q + mval_q * dataIn2;
          k_d     = k_q + DW'(1);
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (RD) begin
          y_out_d   = acc_q;
          y_row_d   = r_q;
          y_valid_d = 1'b1;
          r_d       = r_q + DW'(1);
          done_d    = last_row;
          state_d   = last_row ? S_DONE : S_ROWEND;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      k_q       <= '0;
      end_q     <= '0;
      acc_q     <= '0;
      col_q     <= '0;
      mval_q    <= '0;
      y_out_q   <= '0;
      y_row_q   <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      k_q       <= k_d;
      end_q     <= end_d;
      acc_q     <= acc_d;
      col_q     <= col_d;
      mval_q    <= mval_d;
      y_out_q   <= y_out_d;
      y_row_q   <= y_row_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_row   = y_row_q;
  assign y_valid = y_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: CSR memories, per-row
// expected dot products, pause, clamp and reset scenarios.
module tb_control;

  localparam int          ROWS = 32;
  localparam logic [31:0] RB   = 32'd28220;
  localparam logic [31:0] WB   = 32'd30000;
  localparam logic [31:0] MB   = 32'd170;
  localparam logic [31:0] VB   = 32'd500;
  localparam logic [31:0] CS   = 32'd102;

  logic        Clk;
  logic        Rst;
  logic        RD;
  logic [31:0] addr1, addr2, dataIn1, dataIn2;
  logic [31:0] y_out, y_row;
  logic        y_valid, done;

  logic [31:0] m1 [0:32767];
  logic [31:0] m2 [0:32767];

  int          ptr [0:ROWS];
  logic [31:0] col [0:127];
  logic [31:0] val [0:127];
  logic [31:0] xv  [0:31];
  logic [31:0] spec_y [0:3];

  logic [31:0] exp_q[$];
  int          row_q[$];
  int          vcyc [0:1][0:31];
  int          dcyc [0:1];

  int total;
  int bad;

  assign dataIn1 = m1[addr1[14:0]];
  assign dataIn2 = m2[addr2[14:0]];

  control #(.ROWS(ROWS), .DW(32)) dut (
    .Clk(Clk),
    .v_values_base(VB),
    .wdata_col_base(WB),
    .matrix_base(MB),
    .addr1(addr1),
    .addr2(addr2),
    .dataIn1(dataIn1),
    .dataIn2(dataIn2),
    .Rst(Rst),
    .row_base(RB),
    .RD(RD),
    .csize(CS),
    .y_out(y_out),
    .y_valid(y_valid),
    .y_row(y_row),
    .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic build_mem();
    int c0 [0:13] = '{1, 8, 12, 30, 11, 16, 18, 19, 24,
                      0, 2, 3, 4, 5};
    int v0 [0:13] = '{10, 93, 97, 11, 84, 59, 96, 42, 20,
                      10, 20, 30, 40, 50};
    for (int i = 0; i < 32768; i++) begin
      m1[i] = '0;
      m2[i] = '0;
    end
    ptr[0] = 0; ptr[1] = 4; ptr[2] = 9;
    ptr[3] = 14; ptr[4] = 14;
    for (int i = 4; i <= 30; i++) ptr[i+1] = ptr[i] + (i % 4);
    ptr[ROWS] = 109;
    for (int k = 0; k < 128; k++) begin
      if (k < 14) begin
        col[k] = 32'(c0[k]);
        val[k] = 32'(v0[k]);
      end else begin
        col[k] = 32'((k * 7 + 3) % 32);
        val[k] = 32'(k + 1);
      end
    end
    for (int c = 0; c < 32; c++) xv[c] = 32'(c * 3 + 1);
    xv[1] = 45; xv[8] = 48; xv[12] = 39; xv[30] = 27;
    xv[11] = 6; xv[16] = 1; xv[18] = 64; xv[19] = 49;
    xv[24] = 11;
    xv[0] = 8; xv[2] = 10; xv[3] = 20; xv[4] = 30;
    xv[5] = 118;
    spec_y[0] = 8994; spec_y[1] = 8985;
    spec_y[2] = 7980; spec_y[3] = 0;
    for (int i = 0; i <= ROWS; i++) begin
      m1[RB[14:0] + 15'(i)] = 32'(ptr[i]);
      m1[WB[14:0] + 15'(i)] = 32'(ptr[i]);
    end
    for (int k = 0; k <= 109; k++) begin
      m1[WB[14:0] + 15'(ROWS + 1 + k)] = col[k];
      m2[MB[14:0] + 15'(k)] = val[k];
    end
    for (int c = 0; c < 32; c++) m2[VB[14:0] + 15'(c)] = xv[c];
  endtask

  task automatic push_expected();
    int          kk;
    int          hi;
    logic [31:0] acc;
    exp_q.delete();
    row_q.delete();
    kk = ptr[0];
    for (int r = 0; r < ROWS; r++) begin
      hi  = (ptr[r+1] < int'(CS)) ? ptr[r+1] : int'(CS);
      acc = '0;
      while (kk < hi) begin
        acc = acc + val[kk] * xv[col[kk][4:0]];
        kk++;
      end
      exp_q.push_back(acc);
      row_q.push_back(r);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    RD  = 1'b1;
    repeat (3) @(negedge Clk);
    total++;
    if (addr1 !== 0) begin
      bad++; $display("FAIL rst_addr1 got=%0d want=0", addr1);
    end
    total++;
    if (addr2 !== 0) begin
      bad++; $display("FAIL rst_addr2 got=%0d want=0", addr2);
    end
    total++;
    if (y_out !== 0 || y_row !== 0) begin
      bad++;
      $display("FAIL rst_y got=%0d/%0d want=0/0", y_out, y_row);
    end
    total++;
    if (y_valid !== 0 || done !== 0) begin
      bad++;
      $display("FAIL rst_flags got=%b%b want=00", y_valid, done);
    end
    RD  = 1'b0;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    total++;
    if (addr1 !== 0) begin
      bad++; $display("FAIL idle_addr1 got=%0d want=0", addr1);
    end
    RD = 1'b1;
    @(negedge Clk);
    total++;
    if (addr1 !== RB || addr2 !== 0) begin
      bad++;
      $display("FAIL init_addr got=%0d/%0d want=%0d/0",
               addr1, addr2, RB);
    end
    Rst = 1'b0;
    RD  = 1'b0;
  endtask

  task automatic test_run(input int id, input int pause_at);
    int          cyc;
    int          ne;
    int          wr;
    logic [31:0] want;
    logic [31:0] maxa;
    logic [31:0] a1, a2;
    bit          hit14;
    bit          seen;
    bit          fz;
    bit          stick;
    Rst = 1'b0;
    RD  = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    push_expected();
    RD    = 1'b1;
    cyc   = 0;
    ne    = 0;
    maxa  = '0;
    hit14 = 1'b0;
    seen  = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      if (addr2 >= MB && addr2 < MB + 200 && addr2 > maxa)
        maxa = addr2;
      if (ne == 3 && addr2 == MB + 14) hit14 = 1'b1;
      if (y_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_valid got=row%0d want=none", y_row);
        end else begin
          want = exp_q.pop_front();
          wr   = row_q.pop_front();
          if (y_out !== want) begin
            bad++;
            $display("FAIL y_out row%0d got=%0d want=%0d",
                     wr, y_out, want);
          end
          total++;
          if (y_row !== 32'(wr)) begin
            bad++;
            $display("FAIL y_row got=%0d want=%0d", y_row, wr);
          end
          if (ne < 4) begin
            total++;
            if (y_out !== spec_y[ne]) begin
              bad++;
              $display("FAIL spec_row%0d got=%0d want=%0d",
                       ne, y_out, spec_y[ne]);
            end
          end
        end
        if (ne < 32) vcyc[id][ne] = cyc;
        ne++;
      end
      if (pause_at == cyc) begin
        RD = 1'b0;
        a1 = addr1;
        a2 = addr2;
        fz = 1'b0;
        repeat (3) begin
          @(negedge Clk);
          cyc++;
          if (addr1 !== a1 || addr2 !== a2 || y_valid !== 0)
            fz = 1'b1;
        end
        RD = 1'b1;
        total++;
        if (fz || a2 == 0) begin
          bad++;
          $display("FAIL pause_freeze got=%0d/%0d want=%0d/%0d",
                   addr1, addr2, a1, a2);
        end
      end
      if (done) seen = 1'b1;
    end
    dcyc[id] = cyc;
    total++;
    if (!seen) begin
      bad++; $display("FAIL done_timeout got=0 want=1");
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rows_missing got=%0d want=0", exp_q.size());
    end
    total++;
    if (maxa !== MB + 101) begin
      bad++;
      $display("FAIL clamp_max got=%0d want=%0d", maxa, MB + 101);
    end
    total++;
    if (hit14) begin
      bad++; $display("FAIL empty_row_fetch got=1 want=0");
    end
    stick = 1'b0;
    RD    = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (done !== 1 || y_valid !== 0 || addr1 !== 0) stick = 1'b1;
    end
    RD = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (done !== 1 || y_valid !== 0 || addr2 !== 0) stick = 1'b1;
    end
    total++;
    if (stick) begin
      bad++; $display("FAIL done_sticky got=%b want=1", done);
    end
  endtask

  task automatic test_pause_shift();
    bit sh;
    sh = 1'b0;
    for (int r = 0; r < ROWS; r++)
      if (vcyc[1][r] != vcyc[0][r] + 3) sh = 1'b1;
    total++;
    if (sh) begin
      bad++;
      $display("FAIL pause_shift got=%0d want=%0d",
               vcyc[1][0], vcyc[0][0] + 3);
    end
    total++;
    if (dcyc[1] != dcyc[0] + 3) begin
      bad++;
      $display("FAIL pause_done got=%0d want=%0d",
               dcyc[1], dcyc[0] + 3);
    end
  endtask

  task automatic test_reset_mid();
    bit sp;
    Rst = 1'b0;
    RD  = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    RD  = 1'b1;
    repeat (30) @(negedge Clk);
    Rst = 1'b0;
    #1;
    total++;
    if (addr1 !== 0 || addr2 !== 0 || y_out !== 0 ||
        y_row !== 0 || y_valid !== 0 || done !== 0) begin
      bad++;
      $display("FAIL mid_reset got=%0d/%0d/%0d want=0/0/0",
               addr1, addr2, y_out);
    end
    sp = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (y_valid !== 0 || done !== 0) sp = 1'b1;
    end
    RD  = 1'b0;
    Rst = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      if (y_valid !== 0 || addr1 !== 0) sp = 1'b1;
    end
    total++;
    if (sp) begin
      bad++;
      $display("FAIL mid_reset_spurious got=%b want=0", y_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b0;
    RD    = 1'b0;
    build_mem();
    test_reset();
    test_run(0, 0);
    test_run(1, 5);
    test_pause_shift();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
